// File: rtl/div_ctrl_pkg.sv
// Shared constants for the multi-cycle divide sequencer: bus widths,
// FSM state encodings, handshake levels and the aluop codes that
// execute decodes into start_i / signed_i.
package div_ctrl_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;
  localparam int ALU_OP_W       = 8;

  // Divider FSM state encodings (2 bits).
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

  // Execute uses this to decide whether to raise start_i.
  function automatic logic is_div_op(input logic [ALU_OP_W-1:0] aluop);
    return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
  endfunction

  // Execute uses this to drive signed_i (DIV vs DIVU).
  function automatic logic is_signed_div_op(input logic [ALU_OP_W-1:0] aluop);
    return aluop == EXE_DIV_OP;
  endfunction

endpackage

// File: rtl/div_ctrl.sv
// Multi-cycle divide sequencer for DIV/DIVU. Runs a 32-step restoring
// division, then presents {remainder, quotient} with ready_o until
// execute drops start_i.
//
// Handshake: execute holds start_i high from request until it has seen
// ready_o=1; ready_o and result_o stay valid for as long as start_i stays
// high in DONE, and clear on the edge after start_i falls. Dropping
// start_i or raising annul_i before DONE discards the divide.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      annul_i,
  input  logic                      signed_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o,
  output logic                      busy_o
);

  div_state_e state_q, state_d;

  logic [64:0]               work_q, work_d;
  logic [REG_BUS-1:0]        divisor_q, divisor_d;
  logic [4:0]                cnt_q, cnt_d;
  logic                      neg1_q, neg1_d;
  logic                      neg2_q, neg2_d;
  logic                      signed_q, signed_d;
  logic [DOUBLE_REG_BUS-1:0] result_q, result_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;

  logic [32:0]        diff;
  logic [64:0]        work_step;
  logic [REG_BUS-1:0] quot_fix, rem_fix;
  logic               abort;

  assign abort = annul_i || (start_i == DIV_STOP);

  // State and datapath registers; synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      work_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      signed_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= DIV_RESULT_NOT_READY;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      signed_q  <= signed_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state: annul/stop abort takes precedence over step progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i)
          state_d = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
      end
      DIV_BY_ZERO: state_d = abort ? DIV_FREE : DIV_END;
      DIV_ON: begin
        if (abort)               state_d = DIV_FREE;
        else if (cnt_q == 5'd31) state_d = DIV_END;
      end
      DIV_END: begin
        if (start_i == DIV_STOP) state_d = DIV_FREE;
      end
      default: state_d = DIV_FREE;
    endcase
  end

  // One restoring step: trial-subtract the divisor from the upper window.
  always_comb begin
    diff = work_q[64:32] - {1'b0, divisor_q};
    if (diff[32]) work_step = {work_q[63:0], 1'b0};
    else          work_step = {diff[31:0], work_q[31:0], 1'b1};
    quot_fix = (signed_q && (neg1_q ^ neg2_q)) ? (~work_step[31:0] + 32'd1)
                                               : work_step[31:0];
    rem_fix  = (signed_q && neg1_q) ? (~work_step[64:33] + 32'd1)
                                    : work_step[64:33];
  end

  // Datapath and output next-values, keyed on current and next state.
  always_comb begin
    work_d    = work_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    signed_d  = signed_q;
    result_d  = result_q;
    busy_d    = (state_d == DIV_ON) || (state_d == DIV_BY_ZERO);
    ready_d   = (state_d == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;

    case (state_q)
      DIV_FREE: begin
        if (state_d == DIV_ON) begin
          // Magnitudes only; signs are reapplied to the final result.
          neg1_d    = signed_i && opdata1_i[31];
          neg2_d    = signed_i && opdata2_i[31];
          signed_d  = signed_i;
          divisor_d = neg2_d ? (~opdata2_i + 32'd1) : opdata2_i;
          work_d    = {32'b0, (neg1_d ? (~opdata1_i + 32'd1) : opdata1_i), 1'b0};
          cnt_d     = '0;
        end
        result_d = '0;
      end
      DIV_BY_ZERO: result_d = '0;
      DIV_ON: begin
        if (!abort) begin
          work_d = work_step;
          cnt_d  = cnt_q + 5'd1;
          if (state_d == DIV_END) result_d = {rem_fix, quot_fix};
        end
      end
      DIV_END: begin
        if (state_d == DIV_FREE) result_d = '0;
      end
      default: result_d = '0;
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: reset, unsigned/signed divides, overflow
// and divide-by-zero corners, annul, mid-run reset and result hold.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  div_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: request a divide, wait (bounded) for ready_o, capture the
  // result, then drop start_i and let the DUT return to IDLE.
  // edges counts posedges from the accepting edge (inclusive) to ready_o.
  task automatic do_divide(input logic s, input logic [31:0] a,
                           input logic [31:0] b, output logic [63:0] res,
                           output int edges, output int busy_cycles,
                           output logic timed_out);
    int n;
    start_i   = 1'b1;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    @(posedge clk); #1;
    n = 1;
    busy_cycles = busy_o ? 1 : 0;
    while (!ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy_o) busy_cycles++;
    end
    timed_out = !ready_o;
    edges = n;
    res = result_o;
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (result_o !== 64'd0 || ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got result=%h ready=%b busy=%b want 0/0/0",
               result_o, ready_o, busy_o);
    end
  endtask

  task automatic test_divu_basic();
    logic [63:0] res; int edges, busy_n; logic to;
    do_divide(1'b0, 32'd100, 32'd7, res, edges, busy_n, to);
    checks++;
    if (to || res !== {32'd2, 32'd14}) begin
      errors++;
      $display("FAIL divu_100_7: got %h timeout=%b want %h", res, to, {32'd2, 32'd14});
    end
    checks++;
    if (edges !== 33) begin
      errors++;
      $display("FAIL divu_latency: got %0d edges want 33", edges);
    end
    checks++;
    if (busy_n !== 32) begin
      errors++;
      $display("FAIL divu_busy_cycles: got %0d want 32", busy_n);
    end
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL done_release: got ready=%b result=%h busy=%b want 0/0/0",
               ready_o, result_o, busy_o);
    end
  endtask

  task automatic test_signed();
    logic [63:0] res; int edges, busy_n; logic to;
    do_divide(1'b1, 32'hFFFF_FFF9, 32'd2, res, edges, busy_n, to);
    checks++;
    if (to || res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      errors++;
      $display("FAIL div_m7_2: got %h want %h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    do_divide(1'b1, 32'd7, 32'hFFFF_FFFE, res, edges, busy_n, to);
    checks++;
    if (to || res !== {32'd1, 32'hFFFF_FFFD}) begin
      errors++;
      $display("FAIL div_7_m2: got %h want %h", res, {32'd1, 32'hFFFF_FFFD});
    end
    do_divide(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, res, edges, busy_n, to);
    checks++;
    if (to || res !== {32'hFFFF_FFFF, 32'd3}) begin
      errors++;
      $display("FAIL div_m7_m2: got %h want %h", res, {32'hFFFF_FFFF, 32'd3});
    end
  endtask

  task automatic test_boundaries();
    logic [63:0] res; int edges, busy_n; logic to;
    do_divide(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, edges, busy_n, to);
    checks++;
    if (to || res !== {32'd0, 32'h8000_0000}) begin
      errors++;
      $display("FAIL div_overflow: got %h want %h", res, {32'd0, 32'h8000_0000});
    end
    do_divide(1'b0, 32'hFFFF_FFFF, 32'd1, res, edges, busy_n, to);
    checks++;
    if (to || res !== {32'd0, 32'hFFFF_FFFF}) begin
      errors++;
      $display("FAIL divu_max_1: got %h want %h", res, {32'd0, 32'hFFFF_FFFF});
    end
    do_divide(1'b0, 32'hFFFF_FFF9, 32'd2, res, edges, busy_n, to);
    checks++;
    if (to || res !== {32'd1, 32'h7FFF_FFFC}) begin
      errors++;
      $display("FAIL divu_large: got %h want %h", res, {32'd1, 32'h7FFF_FFFC});
    end
  endtask

  task automatic test_div_by_zero();
    logic [63:0] res; int edges, busy_n; logic to;
    do_divide(1'b0, 32'd5, 32'd0, res, edges, busy_n, to);
    checks++;
    if (to || res !== 64'd0) begin
      errors++;
      $display("FAIL divzero_result: got %h want 0", res);
    end
    checks++;
    if (edges !== 2 || busy_n !== 1) begin
      errors++;
      $display("FAIL divzero_timing: got edges=%0d busy=%0d want 2/1", edges, busy_n);
    end
  endtask

  task automatic test_annul();
    logic [63:0] res; int edges, busy_n; logic to; logic seen_ready;
    seen_ready = 1'b0;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready_o) seen_ready = 1'b1;
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    if (ready_o) seen_ready = 1'b1;
    checks++;
    if (busy_o !== 1'b0 || ready_o !== 1'b0 || seen_ready) begin
      errors++;
      $display("FAIL annul_idle: got busy=%b ready=%b seen_ready=%b want 0/0/0",
               busy_o, ready_o, seen_ready);
    end
    do_divide(1'b0, 32'd9, 32'd3, res, edges, busy_n, to);
    checks++;
    if (to || res !== {32'd0, 32'd3} || edges !== 33) begin
      errors++;
      $display("FAIL annul_then_9_3: got %h edges=%0d want %h edges=33",
               res, edges, {32'd0, 32'd3});
    end
  endtask

  task automatic test_reset_mid_and_hold();
    int n;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd10;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;
    checks++;
    if (result_o !== 64'd0 || ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got result=%h ready=%b busy=%b want 0/0/0",
               result_o, ready_o, busy_o);
    end
    @(posedge clk); #1;
    start_i = 1'b1;
    n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ready_o !== 1'b1 || result_o !== {32'd0, 32'd100}) begin
        errors++;
        $display("FAIL done_hold_%0d: got ready=%b result=%h want 1/%h",
                 i, ready_o, result_o, {32'd0, 32'd100});
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start_i = 1'b0;
    checks++;
    if (result_o !== 64'd0 || ready_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_done: got result=%h ready=%b busy=%b want 0/0/0",
               result_o, ready_o, busy_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; int edges, busy_n; logic to;
    do_divide(1'b0, 32'd1000, 32'd10, res, edges, busy_n, to);
    checks++;
    if (to || res !== {32'd0, 32'd100}) begin
      errors++;
      $display("FAIL b2b_first: got %h want %h", res, {32'd0, 32'd100});
    end
    do_divide(1'b0, 32'd12345, 32'd100, res, edges, busy_n, to);
    checks++;
    if (to || res !== {32'd45, 32'd123}) begin
      errors++;
      $display("FAIL b2b_second: got %h want %h", res, {32'd45, 32'd123});
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_boundaries();
    test_div_by_zero();
    test_annul();
    test_reset_mid_and_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
